mem_bus_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single synchronous on-chip RAM (1-cycle read latency, registered address/write inputs) between the TrashbinCore instruction-fetch port and its data port. It sits between the core's request ports and the RAM, replacing the direct one-master hookup. It issues at most one RAM access per cycle, returns read data to the owning requester one cycle later, and traps out-of-range addresses without touching RAM.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter: requester indices,
// the read in-flight record and the address range test.
package mem_arb_pkg;

  localparam int ADDR_W_DEFAULT = 14;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_idx_e;

  typedef struct packed {
    logic     valid;
    req_idx_e owner;
    logic     fault;
  } inflight_t;

  // Word addresses above the RAM size must never reach the RAM.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> addr_w) == 32'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick with its last-grant register; on contention the
// requester that did not win last time is served.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  req_idx_e last_grant_q;
  req_idx_e last_grant_d;

  always_comb begin
    grant_o      = 2'b00;
    last_grant_d = last_grant_q;
    // Grants are suppressed for the whole time reset is held.
    if (rst_ni) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (last_grant_q == REQ_DATA) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    if (grant_o[0]) begin
      last_grant_d = REQ_FETCH;
    end else if (grant_o[1]) begin
      last_grant_d = REQ_DATA;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= REQ_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous single-port RAM between the fetch and data ports:
// one access per cycle, read data steered back one cycle later, range faults trapped.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              CoreClock,
  input  logic              CoreReset_n,
  input  logic              Req_0,
  input  logic [31:0]       Addr_0,
  input  logic              Write_0,
  input  logic [DATA_W-1:0] WData_0,
  output logic              Grant_0,
  output logic              RValid_0,
  output logic [DATA_W-1:0] RData_0,
  input  logic              Req_1,
  input  logic [31:0]       Addr_1,
  input  logic              Write_1,
  input  logic [DATA_W-1:0] WData_1,
  output logic              Grant_1,
  output logic              RValid_1,
  output logic [DATA_W-1:0] RData_1,
  output logic [ADDR_W-1:0] RamAddress,
  output logic [DATA_W-1:0] RamWData,
  output logic              RamWrite,
  input  logic [DATA_W-1:0] RamRData,
  output logic              FaultFlag,
  output logic [31:0]       FaultAddr
);

  logic [1:0]        grant;
  logic              any_grant;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              in_range;

  inflight_t         inflight_q;
  inflight_t         inflight_d;

  logic              fault_flag_q;
  logic              fault_flag_d;
  logic [31:0]       fault_addr_q;
  logic [31:0]       fault_addr_d;

  logic [1:0]             rvalid;
  logic [1:0][DATA_W-1:0] rdata;
  logic [DATA_W-1:0]      rsp_data;

  rr_arbiter2 u_rr_arbiter2 (
    .clk_i   (CoreClock),
    .rst_ni  (CoreReset_n),
    .req_i   ({Req_1, Req_0}),
    .grant_o (grant)
  );

  assign Grant_0   = grant[0];
  assign Grant_1   = grant[1];
  assign any_grant = |grant;

  assign sel_addr  = grant[1] ? Addr_1  : Addr_0;
  assign sel_wdata = grant[1] ? WData_1 : WData_0;
  assign sel_write = grant[1] ? Write_1 : Write_0;
  assign in_range  = addr_in_range(sel_addr, ADDR_W);

  // Out-of-range accesses still consume the slot but never write the RAM.
  assign RamAddress = sel_addr[ADDR_W-1:0];
  assign RamWData   = sel_wdata;
  assign RamWrite   = any_grant & sel_write & in_range;

  always_comb begin
    inflight_d = '0;
    if (any_grant && !sel_write) begin
      inflight_d.valid = 1'b1;
      inflight_d.owner = grant[1] ? REQ_DATA : REQ_FETCH;
      inflight_d.fault = !in_range;
    end
  end

  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign rsp_data = inflight_q.fault ? '0 : RamRData;

  // RAM data is only present for one cycle, so each port keeps a copy to hold
  // its last response while idle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    assign rvalid[gi] = inflight_q.valid && (inflight_q.owner == ((gi == 0) ? REQ_FETCH : REQ_DATA));
    assign rdata_d    = rvalid[gi] ? rsp_data : rdata_q;
    assign rdata[gi]  = rdata_d;

    always_ff @(posedge CoreClock or negedge CoreReset_n) begin
      if (!CoreReset_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign RValid_0 = rvalid[0];
  assign RValid_1 = rvalid[1];
  assign RData_0  = rdata[0];
  assign RData_1  = rdata[1];

  always_comb begin
    fault_flag_d = fault_flag_q;
    fault_addr_d = fault_addr_q;
    if (any_grant && !in_range && !fault_flag_q) begin
      fault_flag_d = 1'b1;
      fault_addr_d = sel_addr;
    end
  end

  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      fault_flag_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_flag_q <= fault_flag_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign FaultFlag = fault_flag_q;
  assign FaultAddr = fault_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, reset/contention sequences and
// random traffic, all checked each cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          CoreClock;
  logic          CoreReset_n;
  logic          Req_0, Req_1;
  logic [31:0]   Addr_0, Addr_1;
  logic          Write_0, Write_1;
  logic [DW-1:0] WData_0, WData_1;
  logic          Grant_0, Grant_1;
  logic          RValid_0, RValid_1;
  logic [DW-1:0] RData_0, RData_1;
  logic [AW-1:0] RamAddress;
  logic [DW-1:0] RamWData;
  logic          RamWrite;
  logic [DW-1:0] RamRData;
  logic          FaultFlag;
  logic [31:0]   FaultAddr;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CoreClock   (CoreClock),
    .CoreReset_n (CoreReset_n),
    .Req_0       (Req_0),
    .Addr_0      (Addr_0),
    .Write_0     (Write_0),
    .WData_0     (WData_0),
    .Grant_0     (Grant_0),
    .RValid_0    (RValid_0),
    .RData_0     (RData_0),
    .Req_1       (Req_1),
    .Addr_1      (Addr_1),
    .Write_1     (Write_1),
    .WData_1     (WData_1),
    .Grant_1     (Grant_1),
    .RValid_1    (RValid_1),
    .RData_1     (RData_1),
    .RamAddress  (RamAddress),
    .RamWData    (RamWData),
    .RamWrite    (RamWrite),
    .RamRData    (RamRData),
    .FaultFlag   (FaultFlag),
    .FaultAddr   (FaultAddr)
  );

  initial CoreClock = 1'b0;
  always #5 CoreClock = ~CoreClock;

  // Initial RAM contents, shared by the RAM model and the reference model.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h0100_0193) ^ 32'h5A5A_5A5A;
  endfunction

  // Synchronous RAM: registered address, 1-cycle read latency.
  logic [31:0] ram [0:(1<<AW)-1];
  bit ram_ready = 1'b0;
  always @(posedge CoreClock) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(32'(i));
      ram_ready <= 1'b1;
    end else begin
      if (RamWrite) ram[RamAddress] <= RamWData;
      RamRData <= ram[RamAddress];
    end
  end

  // Reference model state (transaction level).
  int          last_m;
  bit          rv_m [2];
  logic [31:0] rd_m [2];
  bit          fflag_m;
  logic [31:0] faddr_m;
  bit          in_reset_m;
  int          won_m;
  logic [31:0] mem_m [logic [31:0]];

  // Stimulus currently presented by each requester.
  bit          req_b   [2];
  logic [31:0] addr_b  [2];
  bit          write_b [2];
  logic [31:0] wdata_b [2];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return init_word(a);
  endfunction

  function automatic void model_reset();
    last_m  = 1;
    rv_m[0] = 0; rv_m[1] = 0;
    rd_m[0] = '0; rd_m[1] = '0;
    fflag_m = 0;
    faddr_m = '0;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check mid-low phase, then advance the model.
  task automatic step();
    int          w;
    bit          inr;
    bit          wr;
    logic [31:0] a;
    logic [31:0] shown;
    @(negedge CoreClock);
    Req_0 = req_b[0]; Addr_0 = addr_b[0]; Write_0 = write_b[0]; WData_0 = wdata_b[0];
    Req_1 = req_b[1]; Addr_1 = addr_b[1]; Write_1 = write_b[1]; WData_1 = wdata_b[1];
    #1;
    w = -1;
    if (!in_reset_m) begin
      if (req_b[0] && req_b[1]) w = (last_m == 0) ? 1 : 0;
      else if (req_b[0])        w = 0;
      else if (req_b[1])        w = 1;
    end
    inr = 0; wr = 0; a = '0;
    if (w >= 0) begin
      a   = addr_b[w];
      inr = ((a >> AW) == 32'd0);
      wr  = write_b[w];
    end
    check1("grant_0", Grant_0, w == 0);
    check1("grant_1", Grant_1, w == 1);
    check1("ram_write", RamWrite, (w >= 0) && wr && inr);
    if (w >= 0) check32("ram_addr", 32'(RamAddress), a % (1 << AW));
    if (w >= 0 && wr) check32("ram_wdata", RamWData, wdata_b[w]);
    check1("rvalid_0", RValid_0, rv_m[0]);
    check1("rvalid_1", RValid_1, rv_m[1]);
    check32("rdata_0", RData_0, rd_m[0]);
    check32("rdata_1", RData_1, rd_m[1]);
    check1("fault_flag", FaultFlag, fflag_m);
    check32("fault_addr", FaultAddr, faddr_m);

    rv_m[0] = 0; rv_m[1] = 0;
    if (w >= 0) begin
      last_m = w;
      shown  = wr ? wdata_b[w] : (inr ? mem_read(a) : 32'h0);
      $display("txn t=%0t port=%0d %s addr=%08h data=%08h%s", $time, w, wr ? "WR" : "RD",
               a, shown, inr ? "" : " out-of-range");
      if (!inr && !fflag_m) begin
        fflag_m = 1;
        faddr_m = a;
      end
      if (wr) begin
        if (inr) mem_m[a] = wdata_b[w];
      end else begin
        rv_m[w] = 1;
        rd_m[w] = inr ? mem_read(a) : 32'h0;
      end
    end
    won_m = w;
  endtask

  task automatic set_req(input int i, input bit r, input bit wr, input logic [31:0] a,
                         input logic [31:0] d);
    req_b[i] = r; write_b[i] = wr; addr_b[i] = a; wdata_b[i] = d;
  endtask

  task automatic idle_all();
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    CoreReset_n = 1'b0;
    in_reset_m  = 1;
    model_reset();
    step();
    step();
    CoreReset_n = 1'b1;
    in_reset_m  = 0;
  endtask

  typedef struct {
    bit          r0; bit wr0; logic [31:0] a0; logic [31:0] d0;
    bit          r1; bit wr1; logic [31:0] a1; logic [31:0] d1;
    logic [1:0]  g;  logic rw; logic [1:0] rv;
    logic [31:0] rd0; logic [31:0] rd1; logic ff;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [4];

    tbl[0]  = '{1,0,32'h10,0,      0,0,0,0,                  2'b01,0,2'b00,32'h0,32'h0,0};
    tbl[1]  = '{0,0,0,0,           0,0,0,0,                  2'b00,0,2'b01,32'hDEADBEEF,32'h0,0};
    tbl[2]  = '{0,0,0,0,           1,1,32'h3FFF,32'h12345678,2'b10,1,2'b00,32'hDEADBEEF,32'h0,0};
    tbl[3]  = '{1,0,32'h3FFF,0,    0,0,0,0,                  2'b01,0,2'b00,32'hDEADBEEF,32'h0,0};
    tbl[4]  = '{0,0,0,0,           0,0,0,0,                  2'b00,0,2'b01,32'h12345678,32'h0,0};
    tbl[5]  = '{0,0,0,0,           1,1,32'h4000,32'hCAFEF00D,2'b10,0,2'b00,32'h12345678,32'h0,0};
    tbl[6]  = '{0,0,0,0,           1,0,32'h8000,0,           2'b10,0,2'b00,32'h12345678,32'h0,1};
    tbl[7]  = '{0,0,0,0,           0,0,0,0,                  2'b00,0,2'b10,32'h12345678,32'h0,1};
    tbl[8]  = '{1,0,32'h10,0,      1,0,32'h3FFF,0,           2'b01,0,2'b00,32'h12345678,32'h0,1};
    tbl[9]  = '{0,0,0,0,           1,0,32'h3FFF,0,           2'b10,0,2'b01,32'hDEADBEEF,32'h0,1};
    tbl[10] = '{0,0,0,0,           0,0,0,0,                  2'b00,0,2'b10,32'hDEADBEEF,32'h12345678,1};
    tbl[11] = '{0,0,0,0,           0,0,0,0,                  2'b00,0,2'b00,32'hDEADBEEF,32'h12345678,1};
    tbl[12] = '{0,0,0,0,           1,0,32'h8000,0,           2'b10,0,2'b00,32'hDEADBEEF,32'h12345678,1};
    tbl[13] = '{0,0,0,0,           0,0,0,0,                  2'b00,0,2'b10,32'hDEADBEEF,32'h0,1};

    idle_all();
    Req_0 = 0; Req_1 = 0; Addr_0 = '0; Addr_1 = '0;
    Write_0 = 0; Write_1 = 0; WData_0 = '0; WData_1 = '0;

    // Reset: requests present but nothing may be granted or written.
    set_req(0, 1, 1, 32'h20, 32'h11111111);
    set_req(1, 1, 0, 32'h21, '0);
    do_reset();
    idle_all();

    // Directed vector table.
    foreach (tbl[k]) begin
      set_req(0, tbl[k].r0, tbl[k].wr0, tbl[k].a0, tbl[k].d0);
      set_req(1, tbl[k].r1, tbl[k].wr1, tbl[k].a1, tbl[k].d1);
      step();
      check1($sformatf("tbl%0d_grant_0", k), Grant_0, tbl[k].g[0]);
      check1($sformatf("tbl%0d_grant_1", k), Grant_1, tbl[k].g[1]);
      check1($sformatf("tbl%0d_ram_write", k), RamWrite, tbl[k].rw);
      check1($sformatf("tbl%0d_rvalid_0", k), RValid_0, tbl[k].rv[0]);
      check1($sformatf("tbl%0d_rvalid_1", k), RValid_1, tbl[k].rv[1]);
      check32($sformatf("tbl%0d_rdata_0", k), RData_0, tbl[k].rd0);
      check32($sformatf("tbl%0d_rdata_1", k), RData_1, tbl[k].rd1);
      check1($sformatf("tbl%0d_fault_flag", k), FaultFlag, tbl[k].ff);
    end
    check32("tbl_fault_addr_first", FaultAddr, 32'h4000);
    idle_all();

    // Contention right after reset: strict alternation starting with fetch.
    do_reset();
    order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
    set_req(0, 1, 0, 32'h100, '0);
    set_req(1, 1, 0, 32'h200, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      check1($sformatf("cont%0d_grant_0", k), Grant_0, order[k] == 0);
      check32($sformatf("cont%0d_ram_addr", k), 32'(RamAddress), (order[k] == 0) ? 32'h100 : 32'h200);
    end
    idle_all();
    step();

    // Fault then reset with a read in flight: response dropped, state cleared.
    set_req(1, 1, 1, 32'h5000, 32'hBAD0BAD0);
    step();
    idle_all();
    set_req(0, 1, 0, 32'h10, '0);
    step();
    idle_all();
    CoreReset_n = 1'b0;
    in_reset_m  = 1;
    model_reset();
    #1;
    check1("rst_rvalid_0", RValid_0, 1'b0);
    check1("rst_rvalid_1", RValid_1, 1'b0);
    check1("rst_fault_flag", FaultFlag, 1'b0);
    step();
    step();
    CoreReset_n = 1'b1;
    in_reset_m  = 0;
    step();
    step();
    check1("post_rst_rvalid_0", RValid_0, 1'b0);
    check1("post_rst_fault_flag", FaultFlag, 1'b0);
    set_req(0, 1, 0, 32'h30, '0);
    set_req(1, 1, 0, 32'h31, '0);
    step();
    check1("post_rst_lastgrant", Grant_0, 1'b1);
    set_req(0, 0, 0, '0, '0);
    step();
    idle_all();
    step();

    // Random traffic: each requester holds its request until granted.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_b[i] && $urandom_range(0, 99) < 60) begin
          logic [31:0] a;
          if ($urandom_range(0, 19) == 0)
            a = ($urandom_range(0, 1) != 0) ? (32'h4000 + 32'($urandom_range(0, 7))) : 32'h8000_0000;
          else
            a = (($urandom_range(0, 1) != 0) ? 32'h3FF0 : 32'h0) + 32'($urandom_range(0, 15));
          set_req(i, 1, $urandom_range(0, 1) != 0, a, $urandom);
        end
      end
      step();
      if (won_m >= 0) req_b[won_m] = 0;
    end
    idle_all();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
